// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte port among N_REQ requesters.
// A grant is held for a whole message and is released by a watchdog if the owner goes quiet.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               uart_tx_available,
    output logic [7:0]         uart_tx_data,
    input  logic               uart_tx_ack,
    output logic               timeout_pulse
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_reg;
    logic [OW-1:0]    owner_reg;
    logic [OW-1:0]    last_owner_reg;
    logic [CW-1:0]    idle_cnt_reg;
    logic [N_REQ-1:0] grant_reg;
    logic             timeout_pulse_reg;

    logic [OW-1:0]    pick_idx;
    logic             pick_found;
    logic [OW:0]      pick_sum;
    logic             owner_valid;
    logic             owner_last;
    logic             byte_taken;
    logic [7:0]       data_slice [N_REQ];

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pick_sum = {1'b0, last_owner_reg} + (OW+1)'(k);
            if (pick_sum >= (OW+1)'(N_REQ))
                pick_sum = pick_sum - (OW+1)'(N_REQ);
            if (!pick_found && req_valid[pick_sum[OW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pick_sum[OW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_slice[gi] = req_data[8*gi +: 8];
            assign req_ack[gi]    = grant_reg[gi] & uart_tx_ack;
        end
    endgenerate

    assign owner_valid       = req_valid[owner_reg];
    assign owner_last        = req_last[owner_reg];
    assign byte_taken        = uart_tx_ack & uart_tx_available;
    assign grant             = grant_reg;
    assign uart_tx_available = (state_reg == LOCKED) & owner_valid;
    assign uart_tx_data      = (state_reg == LOCKED) ? data_slice[owner_reg] : 8'h00;
    assign timeout_pulse     = timeout_pulse_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            owner_reg         <= '0;
            last_owner_reg    <= OW'(N_REQ - 1);
            idle_cnt_reg      <= '0;
            grant_reg         <= '0;
            timeout_pulse_reg <= 1'b0;
        end else begin
            timeout_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    idle_cnt_reg <= '0;
                    if (pick_found) begin
                        owner_reg <= pick_idx;
                        grant_reg <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        state_reg <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (byte_taken && owner_last) begin
                        state_reg      <= IDLE;
                        grant_reg      <= '0;
                        last_owner_reg <= owner_reg;
                        idle_cnt_reg   <= '0;
                    end else if (owner_valid) begin
                        // Back-pressure with valid held high never counts as idle.
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg == CW'(TIMEOUT - 1)) begin
                        state_reg         <= IDLE;
                        grant_reg         <= '0;
                        last_owner_reg    <= owner_reg;
                        idle_cnt_reg      <= '0;
                        timeout_pulse_reg <= 1'b1;
                    end else if (idle_cnt_reg != CW'(TIMEOUT)) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural requesters and an always-ready/stallable UART.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic           uart_tx_available;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_ack;
    logic           timeout_pulse;
    logic           uart_ready;

    always #5 clk = ~clk;

    assign uart_tx_ack = uart_ready & uart_tx_available;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ack           (req_ack),
        .grant             (grant),
        .uart_tx_available (uart_tx_available),
        .uart_tx_data      (uart_tx_data),
        .uart_tx_ack       (uart_tx_ack),
        .timeout_pulse     (timeout_pulse)
    );

    int checks = 0;
    int passes = 0;

    logic [7:0] mdata [N][8];
    int         mlen  [N];
    int         mptr  [N];
    bit         mstall[N];

    int         cyc = 0;
    int         log_req [$];
    logic [7:0] log_byte[$];
    int         log_cyc [$];
    int         pulse_cnt = 0;
    int         pulse_cyc = -1;

    logic [N-1:0] s_grant;
    logic         s_avail;
    logic [7:0]   s_data;
    logic         s_pulse;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = (mptr[i] < mlen[i]) && !mstall[i];
            req_data[8*i +: 8] = (mptr[i] < mlen[i]) ? mdata[i][mptr[i]] : 8'h00;
            req_last[i]      = (mptr[i] == mlen[i] - 1);
        end
    endtask

    task automatic load(input int r, input int len, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2);
        mdata[r][0] = b0;
        mdata[r][1] = b1;
        mdata[r][2] = b2;
        mlen[r]     = len;
        mptr[r]     = 0;
        mstall[r]   = 1'b0;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++)
            if (mptr[i] < mlen[i] && !mstall[i]) p = 1'b1;
        return p;
    endfunction

    // One clock cycle: inputs just after the rising edge, outputs sampled on the falling edge.
    task automatic step();
        int ridx;
        drive();
        @(negedge clk);
        s_grant = grant;
        s_avail = uart_tx_available;
        s_data  = uart_tx_data;
        s_pulse = timeout_pulse;
        if (uart_tx_ack) begin
            ridx = -1;
            for (int i = 0; i < N; i++) if (req_ack[i]) ridx = i;
            log_req.push_back(ridx);
            log_byte.push_back(uart_tx_data);
            log_cyc.push_back(cyc);
            $display("cyc %0d: uart accepts 0x%02h from req %0d", cyc, uart_tx_data, ridx);
        end
        for (int i = 0; i < N; i++) if (req_ack[i]) mptr[i]++;
        if (timeout_pulse) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_msgs(input string tag, input int maxc);
        int n = 0;
        while (pending() && n < maxc) begin
            step();
            n++;
        end
        check_eq({tag, "_done"}, pending(), 0);
    endtask

    task automatic clear_log();
        log_req.delete();
        log_byte.delete();
        log_cyc.delete();
    endtask

    task automatic check_round(input string tag, input int t0);
        int e;
        check_eq({tag, "_count"}, log_req.size(), 8);
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < 2; k++) begin
                e = 2 * r + k;
                check_eq($sformatf("%s_req%0d", tag, e), log_req[e], r);
                check_eq($sformatf("%s_byte%0d", tag, e), log_byte[e], 8'hA0 + 8'(16 * r + k));
                check_eq($sformatf("%s_cyc%0d", tag, e), log_cyc[e], t0 + 1 + 3 * r + k);
            end
        end
    endtask

    initial begin
        int t0;
        int td;
        int n;
        int bad;

        uart_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            mlen[i] = 0; mptr[i] = 0; mstall[i] = 1'b0;
        end
        drive();

        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_avail", uart_tx_available, 0);
        check_eq("rst_data", uart_tx_data, 0);
        check_eq("rst_ack", req_ack, 0);
        check_eq("rst_pulse", timeout_pulse, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fairness: two rounds of four 2-byte messages
        for (int rnd = 0; rnd < 2; rnd++) begin
            clear_log();
            for (int r = 0; r < N; r++) load(r, 2, 8'hA0 + 8'(16 * r), 8'hA1 + 8'(16 * r), 8'h00);
            t0 = cyc;
            run_msgs($sformatf("fair%0d", rnd), 60);
            check_round($sformatf("fair%0d", rnd), t0);
        end

        // Single requester, three bytes back to back
        clear_log();
        load(0, 3, 8'h41, 8'h42, 8'h43);
        t0 = cyc;
        step();
        check_eq("single_idle_grant", s_grant, 0);
        check_eq("single_idle_avail", s_avail, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("single_grant%0d", k), s_grant, 4'b0001);
            check_eq($sformatf("single_data%0d", k), s_data, 8'h41 + 8'(k));
        end
        step();
        check_eq("single_after_grant", s_grant, 0);
        check_eq("single_count", log_req.size(), 3);
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("single_cyc%0d", k), log_cyc[k], t0 + 1 + k);

        // Rotation: after req2, req3 beats req0
        load(2, 1, 8'h22, 8'h00, 8'h00);
        run_msgs("rot_pre", 10);
        clear_log();
        load(0, 1, 8'h50, 8'h00, 8'h00);
        load(3, 1, 8'h53, 8'h00, 8'h00);
        t0 = cyc;
        run_msgs("rot", 10);
        check_eq("rot_first_req", log_req[0], 3);
        check_eq("rot_first_cyc", log_cyc[0], t0 + 1);
        check_eq("rot_second_req", log_req[1], 0);
        check_eq("rot_second_cyc", log_cyc[1], t0 + 3);

        // Back-pressure: UART stalls mid-message far beyond TIMEOUT
        clear_log();
        pulse_cnt = 0;
        load(1, 3, 8'h61, 8'h62, 8'h63);
        step();
        step();
        uart_ready = 1'b0;
        load(2, 1, 8'h72, 8'h00, 8'h00);
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (s_grant != 4'b0010) bad++;
        end
        check_eq("bp_grant_held", bad, 0);
        check_eq("bp_no_pulse", pulse_cnt, 0);
        uart_ready = 1'b1;
        run_msgs("bp", 20);
        check_eq("bp_count", log_req.size(), 4);
        check_eq("bp_b2_req", log_req[2], 1);
        check_eq("bp_b2_data", log_byte[2], 8'h63);
        check_eq("bp_b3_req", log_req[3], 2);
        check_eq("bp_b3_data", log_byte[3], 8'h72);
        check_eq("bp_no_pulse_end", pulse_cnt, 0);

        // Watchdog: req0 goes quiet mid-message while req3 waits
        clear_log();
        pulse_cnt = 0;
        load(0, 2, 8'h10, 8'h11, 8'h00);
        step();
        step();
        mstall[0] = 1'b1;
        load(3, 1, 8'h33, 8'h00, 8'h00);
        td = cyc;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_pulse && n < 40);
        check_eq("wd_pulse_cyc", pulse_cyc - td, TO);
        check_eq("wd_pulse_grant", s_grant, 0);
        step();
        check_eq("wd_grant_next", s_grant, 4'b1000);
        check_eq("wd_pulse_once", s_pulse, 0);
        check_eq("wd_pulse_cnt", pulse_cnt, 1);
        run_msgs("wd", 10);
        check_eq("wd_b0", log_byte[0], 8'h10);
        check_eq("wd_b1_req", log_req[1], 3);
        check_eq("wd_b1_data", log_byte[1], 8'h33);
        mlen[0] = 0; mptr[0] = 0; mstall[0] = 1'b0;

        // Asynchronous reset in the middle of a message
        load(1, 3, 8'h81, 8'h82, 8'h83);
        step();
        step();
        check_eq("ar_pre_grant", grant, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_grant", grant, 0);
        check_eq("ar_avail", uart_tx_available, 0);
        check_eq("ar_data", uart_tx_data, 0);
        check_eq("ar_ack", req_ack, 0);
        check_eq("ar_pulse", timeout_pulse, 0);
        for (int i = 0; i < N; i++) begin
            mlen[i] = 0; mptr[i] = 0; mstall[i] = 1'b0;
        end
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        clear_log();
        load(0, 1, 8'h90, 8'h00, 8'h00);
        load(1, 1, 8'h91, 8'h00, 8'h00);
        t0 = cyc;
        run_msgs("ar", 10);
        check_eq("ar_first_req", log_req[0], 0);
        check_eq("ar_first_cyc", log_cyc[0], t0 + 1);
        check_eq("ar_second_req", log_req[1], 1);
        check_eq("ar_second_data", log_byte[1], 8'h91);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
